// File: rtl/accel_loader.sv
`default_nettype none
// =============================================================================
// Module : accel_loader
// Copies B then A from source memory into the accelerator and, once the
// result is ready, copies C back out to destination memory.
// Rev    : 1.0  initial release
// =============================================================================
module accel_loader #(
   parameter int         BITS    = 8,
   parameter int         N       = 8,
   parameter int         WIDTH   = 4,
   parameter logic [9:0] OFFCET  = 10'd128,
   parameter int         TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   output logic                    src_rd,
   output logic [5:0]              src_addr,
   input  logic [BITS*WIDTH-1:0]   src_data,
   output logic                    acc_select,
   output logic                    acc_wr_en,
   output logic [9:0]              acc_addr,
   output logic [BITS*WIDTH-1:0]   acc_wdata,
   input  logic [BITS*WIDTH-1:0]   acc_rdata,
   input  logic                    b_ready,
   input  logic                    c_ready,
   output logic                    dst_we,
   output logic [3:0]              dst_addr,
   output logic [BITS*WIDTH-1:0]   dst_data,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int CW = $clog2(N*N/WIDTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] c_WPM      = CW'(N*N/WIDTH);
   localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [9:0]    c_B_BASE   = OFFCET + 10'd64;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_B = 3'd1,
      S_WAIT_B = 3'd2,
      S_LOAD_A = 3'd3,
      S_WAIT_C = 3'd4,
      S_READ_C = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [TW-1:0]   r_wait;
   logic            r_src_rd;
   logic [5:0]      r_src_addr;
   logic            r_acc_select;
   logic            r_acc_wr_en;
   logic [9:0]      r_acc_addr;
   logic            r_dst_we;
   logic [3:0]      r_dst_addr;
   logic            r_busy;
   logic            r_done;
   logic            r_err;

   logic [CW-1:0]   w_cnt_nxt;
   logic            w_more;
   logic [5:0]      w_src_base;
   logic [9:0]      w_acc_base;
   logic [9:0]      w_cnt_off;
   logic [9:0]      w_nxt_off;
   logic            w_flag;

   // r_cnt is the cycle index inside a transfer state; outputs are computed one cycle ahead
   assign w_cnt_nxt  = r_cnt + 1'b1;
   assign w_more     = (w_cnt_nxt < c_WPM);
   assign w_src_base = (r_state == S_LOAD_B) ? 6'(N*N/WIDTH) : 6'd0;
   assign w_acc_base = (r_state == S_LOAD_B) ? c_B_BASE : OFFCET;
   assign w_cnt_off  = 10'({r_cnt, 2'b00});
   assign w_nxt_off  = 10'({w_cnt_nxt, 2'b00});
   assign w_flag     = (r_state == S_WAIT_B) ? b_ready : c_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_wait       <= '0;
         r_src_rd     <= 1'b0;
         r_src_addr   <= '0;
         r_acc_select <= 1'b0;
         r_acc_wr_en  <= 1'b0;
         r_acc_addr   <= '0;
         r_dst_we     <= 1'b0;
         r_dst_addr   <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state    <= S_LOAD_B;
                  r_busy     <= 1'b1;
                  r_err      <= 1'b0;
                  r_cnt      <= '0;
                  r_src_rd   <= 1'b1;
                  r_src_addr <= 6'(N*N/WIDTH);
               end
            end
            S_LOAD_B, S_LOAD_A: begin
               if (r_cnt == c_WPM) begin
                  r_state      <= (r_state == S_LOAD_B) ? S_WAIT_B : S_WAIT_C;
                  r_cnt        <= '0;
                  r_wait       <= '0;
                  r_src_rd     <= 1'b0;
                  r_src_addr   <= '0;
                  r_acc_select <= 1'b0;
                  r_acc_wr_en  <= 1'b0;
                  r_acc_addr   <= '0;
               end else begin
                  r_cnt        <= w_cnt_nxt;
                  r_src_rd     <= w_more;
                  r_src_addr   <= w_more ? (w_src_base + 6'(w_cnt_nxt)) : 6'd0;
                  r_acc_select <= 1'b1;
                  r_acc_wr_en  <= 1'b1;
                  r_acc_addr   <= w_acc_base + w_cnt_off;
               end
            end
            S_WAIT_B, S_WAIT_C: begin
               if (w_flag) begin
                  r_wait <= '0;
                  r_cnt  <= '0;
                  if (r_state == S_WAIT_B) begin
                     r_state    <= S_LOAD_A;
                     r_src_rd   <= 1'b1;
                     r_src_addr <= 6'd0;
                  end else begin
                     r_state      <= S_READ_C;
                     r_acc_select <= 1'b1;
                     r_acc_addr   <= OFFCET;
                  end
               end else if (r_wait == c_TMO_LAST) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_wait  <= '0;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_READ_C: begin
               if (r_cnt == c_WPM) begin
                  r_state      <= S_DONE;
                  r_done       <= 1'b1;
                  r_cnt        <= '0;
                  r_dst_we     <= 1'b0;
                  r_dst_addr   <= '0;
                  r_acc_select <= 1'b0;
                  r_acc_addr   <= '0;
               end else begin
                  r_cnt        <= w_cnt_nxt;
                  r_acc_select <= w_more;
                  r_acc_addr   <= w_more ? (OFFCET + w_nxt_off) : 10'd0;
                  r_dst_we     <= 1'b1;
                  r_dst_addr   <= 4'(r_cnt);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign src_rd     = r_src_rd;
   assign src_addr   = r_src_addr;
   assign acc_select = r_acc_select;
   assign acc_wr_en  = r_acc_wr_en;
   assign acc_addr   = r_acc_addr;
   // Data is a straight pass-through in the cycle the source/accelerator presents it
   assign acc_wdata  = r_acc_wr_en ? src_data : '0;
   assign dst_we     = r_dst_we;
   assign dst_addr   = r_dst_addr;
   assign dst_data   = r_dst_we ? acc_rdata : '0;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_accel_loader.sv
`default_nettype none
// =============================================================================
// Module : tb_accel_loader
// Random and directed jobs against source-memory and matrix-multiplier models.
// Rev    : 1.0  initial release
// =============================================================================
module tb_accel_loader;

   localparam logic [9:0] OFF = 10'd128;
   localparam int         TMO = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        b_ready = 1'b0;
   logic        c_ready = 1'b0;
   logic        src_rd;
   logic [5:0]  src_addr;
   logic [31:0] src_data;
   logic        acc_select;
   logic        acc_wr_en;
   logic [9:0]  acc_addr;
   logic [31:0] acc_wdata;
   logic [31:0] acc_rdata;
   logic        dst_we;
   logic [3:0]  dst_addr;
   logic [31:0] dst_data;
   logic        busy;
   logic        done;
   logic        err;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] srcmem [32];
   logic [31:0] amem   [256];
   logic [31:0] mdl_a  [16];
   logic [31:0] mdl_b  [16];
   logic [41:0] aw [$];
   logic [35:0] dw [$];

   accel_loader #(
      .BITS(8), .N(8), .WIDTH(4), .OFFCET(OFF), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
      .acc_select(acc_select), .acc_wr_en(acc_wr_en), .acc_addr(acc_addr),
      .acc_wdata(acc_wdata), .acc_rdata(acc_rdata),
      .b_ready(b_ready), .c_ready(c_ready),
      .dst_we(dst_we), .dst_addr(dst_addr), .dst_data(dst_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] elem(input logic [31:0] m [16], input int e);
      logic [31:0] wd;
      wd = m[e / 4];
      return wd[8*(e % 4) +: 8];
   endfunction

   // Word w of C = A*B, 8x8 row-major 8-bit elements, four per word, lane 0 in bits 7:0
   function automatic logic [31:0] mm_word(input logic [31:0] a [16], input logic [31:0] b [16], input int w);
      logic [31:0] r;
      int e, row, col, s;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         e = w*4 + l;
         row = e / 8;
         col = e % 8;
         s = 0;
         for (int k = 0; k < 8; k++)
            s += int'(elem(a, row*8 + k)) * int'(elem(b, k*8 + col));
         r[8*l +: 8] = s[7:0];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (src_rd) src_data <= srcmem[src_addr[4:0]];
   end

   always @(posedge clk) begin
      if (acc_select && acc_wr_en) amem[acc_addr[9:2]] <= acc_wdata;
      if (acc_select && !acc_wr_en && acc_addr >= OFF && acc_addr < OFF + 10'd64) begin
         for (int i = 0; i < 16; i++) begin
            mdl_a[i] = amem[32 + i];
            mdl_b[i] = amem[48 + i];
         end
         acc_rdata <= mm_word(mdl_a, mdl_b, int'((acc_addr - OFF) >> 2));
      end else begin
         acc_rdata <= '0;
      end
   end

   always @(negedge clk) begin
      check("wr_dst_excl", 64'(acc_wr_en & dst_we), 64'd0);
      if (acc_wr_en) begin
         aw.push_back({acc_addr, acc_wdata});
         check("sel_on_wr", 64'(acc_select), 64'd1);
      end
      if (dst_we) dw.push_back({dst_addr, dst_data});
   end

   task automatic fill_src_rand();
      for (int i = 0; i < 32; i++) srcmem[i] = $urandom;
   endtask

   // Called at a negedge; start is sampled on the next posedge (cycle 0)
   task automatic run_job(input int db, input int dc, input int rs1, input int rs2, input int rst_at,
                          output int lat, output int errc, output int ndone);
      lat = -1; errc = -1; ndone = 0;
      aw.delete();
      dw.delete();
      b_ready = 1'b0;
      c_ready = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 3000; k++) begin
         start   = (k == rs1) || (k == rs2);
         b_ready = (k >= 18 + db);
         c_ready = (k >= 36 + db + dc);
         if (k == 1) check("busy_err_after_start", 64'({busy, err}), 64'b10);
         if (k == rst_at) begin
            check("pre_rst_write", 64'({acc_wr_en, acc_addr}), 64'({1'b1, OFF + 10'd16}));
            rst = 1'b1;
            #1;
            check("rst_ctrl_zero", 64'({src_rd, src_addr, acc_select, acc_wr_en, acc_addr,
                                        dst_we, dst_addr, busy, done, err}), 64'd0);
            check("rst_data_zero", {acc_wdata, dst_data}, 64'd0);
            break;
         end
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = k;
               check("busy_in_done", 64'(busy), 64'd1);
            end
         end
         if (lat >= 0 && k == lat + 1) check("busy_after_done", 64'(busy), 64'd0);
         if (err && errc < 0) errc = k;
         if ((lat >= 0 && k >= lat + 4) || (errc >= 0 && k >= errc + 4)) break;
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic check_job(input string tag, input int exp_lat, input int lat, input int ndone);
      logic [31:0] a [16];
      logic [31:0] b [16];
      logic [41:0] ew;
      logic [35:0] ed;
      for (int j = 0; j < 16; j++) begin
         a[j] = srcmem[j];
         b[j] = srcmem[16 + j];
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_ndone"}, 64'(ndone), 64'd1);
      check({tag, "_nacc_wr"}, 64'(aw.size()), 64'd32);
      check({tag, "_ndst_wr"}, 64'(dw.size()), 64'd16);
      check({tag, "_idle_after"}, 64'({busy, err}), 64'd0);
      for (int j = 0; j < 32; j++) begin
         if (j < 16) ew = {OFF + 10'd64 + 10'(4*j), b[j]};
         else        ew = {OFF + 10'(4*(j - 16)), a[j - 16]};
         check({tag, "_acc_wr"}, (j < aw.size()) ? 64'(aw[j]) : '1, 64'(ew));
      end
      for (int i = 0; i < 16; i++) begin
         ed = {4'(i), mm_word(a, b, i)};
         check({tag, "_dst_wr"}, (i < dw.size()) ? 64'(dw[i]) : '1, 64'(ed));
      end
   endtask

   initial begin
      int lat, errc, nd, db, dc;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 64'({src_rd, src_addr, acc_select, acc_wr_en, acc_addr,
                               dst_we, dst_addr, busy, done, err}), 64'd0);
      check("reset_data", {acc_wdata, dst_data}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         srcmem[i]      = 32'(i);
         srcmem[16 + i] = 32'h100 + 32'(i);
      end
      run_job(0, 0, 0, 0, 0, lat, errc, nd);
      check_job("basic", 54, lat, nd);

      for (int t = 0; t < 4; t++) begin
         db = int'($urandom_range(0, 20));
         dc = int'($urandom_range(0, 20));
         fill_src_rand();
         run_job(db, dc, 0, 0, 0, lat, errc, nd);
         check_job("rand", 54 + db + dc, lat, nd);
      end

      fill_src_rand();
      run_job(0, 10, 0, 0, 0, lat, errc, nd);
      check_job("c_late", 64, lat, nd);

      fill_src_rand();
      run_job(0, 0, 5, 40, 0, lat, errc, nd);
      check_job("restart", 54, lat, nd);

      // b_ready never rises
      fill_src_rand();
      run_job(100000, 0, 0, 0, 0, lat, errc, nd);
      check("to_err_cycle", 64'(errc), 64'(18 + TMO));
      check("to_ndone", 64'(nd), 64'd0);
      check("to_no_a_writes", 64'(aw.size()), 64'd16);
      check("to_no_dst", 64'(dw.size()), 64'd0);
      check("to_busy_err", 64'({busy, err}), 64'b01);

      fill_src_rand();
      run_job(0, 0, 0, 0, 0, lat, errc, nd);
      check_job("after_to", 54, lat, nd);

      run_job(100000, 0, 0, 0, 0, lat, errc, nd);
      check("to2_err_set", 64'(err), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_clears_err", 64'(err), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      fill_src_rand();
      run_job(0, 0, 0, 0, 24, lat, errc, nd);
      @(negedge clk);
      rst = 1'b0;
      for (int q = 0; q < 40; q++) begin
         check("quiet_after_rst", 64'({src_rd, acc_select, acc_wr_en, dst_we, busy, done}), 64'd0);
         @(negedge clk);
      end

      fill_src_rand();
      run_job(0, 0, 0, 0, 0, lat, errc, nd);
      check_job("rerun", 54, lat, nd);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/accel_loader.md
ACCEL_LOADER -- requirements
Module: accel_loader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  BITS, 8, element width in bits
  N, 8, matrix dimension
  WIDTH, 4, elements per bus word; BITS*WIDTH SHALL equal 32
  OFFCET, 10'd128, accelerator byte base of A and C; B base = OFFCET+64
  TIMEOUT, 255, max cycles waited for a ready flag
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  reset; asynchronous, active-high
  start  in  1  begin one A*B transfer job
  src_rd  out  1  source memory read strobe
  src_addr  out  6  source word index: 0..15 = A, 16..31 = B
  src_data  in  32  source read data, valid 1 cycle after src_rd
  acc_select  out  1  accelerator chip select
  acc_wr_en  out  1  accelerator write enable
  acc_addr  out  10  accelerator byte address
  acc_wdata  out  32  accelerator write data
  acc_rdata  in  32  accelerator read data, valid 1 cycle after address
  b_ready  in  1  accelerator has accepted full B
  c_ready  in  1  accelerator result C available
  dst_we  out  1  destination memory write strobe
  dst_addr  out  4  destination word index 0..15
  dst_data  out  32  destination write data
  busy  out  1  job in progress
  done  out  1  one-cycle job-complete pulse
  err  out  1  sticky timeout flag

Function
REQ-003 Words per matrix SHALL be WPM = N*N/WIDTH (16 at defaults); accelerator address of word i SHALL be base + 4*i.
REQ-004 States SHALL be IDLE, LOAD_B, WAIT_B, LOAD_A, WAIT_C, READ_C, DONE.
REQ-005 IDLE: start=1 -> LOAD_B, busy=1 next cycle, err cleared; start while busy SHALL be ignored.
REQ-006 LOAD_B: src_rd=1 with src_addr=16+j on cycle j (j=0..15); acc_wr_en=1, acc_select=1, acc_addr=OFFCET+64+4*j, acc_wdata=src_data on cycle j+1; 16 consecutive write cycles, 17 cycles in state, then WAIT_B.
REQ-007 WAIT_B: b_ready=1 -> LOAD_A next cycle; b_ready sampled on the first WAIT_B cycle counts.
REQ-008 LOAD_A: as REQ-006 with src_addr=j, acc_addr=OFFCET+4*j; then WAIT_C.
REQ-009 WAIT_C: c_ready=1 -> READ_C next cycle.
REQ-010 Wait counter SHALL reset on entry to WAIT_B/WAIT_C; counter reaching TIMEOUT with flag still low -> err=1, IDLE, busy=0, no done pulse.
REQ-011 READ_C: acc_select=1, acc_wr_en=0, acc_addr=OFFCET+4*j on cycle j (j=0..15); dst_we=1, dst_addr=j, dst_data=acc_rdata on cycle j+1; 17 cycles, then DONE.
REQ-012 DONE: done=1 for exactly one cycle, busy=0 from the following cycle, return to IDLE.
REQ-013 acc_wr_en and dst_we SHALL never be high in the same cycle; acc_select=0 outside LOAD_B, LOAD_A, READ_C pipelines.
REQ-014 Word counters SHALL be log2(WPM)+1 bits, no wrap beyond WPM-1; address arithmetic truncated to 10 bits.
REQ-015 Data paths SHALL pass 32-bit words unmodified (no element reordering).
REQ-016 Job latency with ready flags already high SHALL be 17+1+17+1+17+1 = 54 cycles from start-sample to done.

Reset
REQ-017 rst=1 SHALL immediately force IDLE and all outputs to 0 (src_addr, acc_addr, acc_wdata, dst_addr, dst_data included), err cleared.
REQ-018 rst asserted mid-job SHALL abort with no further strobes; after release, no job runs until a new start.

Verification
REQ-019 Src A[i]=i, B[i]=0x100+i, b_ready/c_ready tied 1, pulse start -> 16 writes to 0x0C0..0x0FC then 16 to 0x080..0x0BC, 16 reads, dst[i]=acc model data, done at cycle 54.
REQ-020 b_ready held 0 -> after TIMEOUT=255 wait cycles err=1, busy=0, done never pulses, no A writes.
REQ-021 c_ready raised 10 cycles into WAIT_C -> READ_C starts next cycle, done 10 cycles later than REQ-019.
REQ-022 rst pulsed on 5th write of LOAD_A -> all outputs 0 same cycle, no strobes until next start; rerun completes correctly.
REQ-023 start re-pulsed during LOAD_B and during READ_C -> ignored, single done pulse, exact 54-cycle latency.
REQ-024 Assertions over all runs: acc_wr_en & dst_we never both 1; exactly 32 acc writes and 16 dst writes per successful job.
